// File: rtl/nibble_add_seq.sv
// Wide adder sequencer: drives one external 4-bit adder a nibble per clock,
// LSB first, with valid/ready handshakes on the operand and result sides.
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   op_cin,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_ZERO = IW'(0);

  logic [1:0]    state_q,  state_d;
  logic [IW-1:0] idx_q,    idx_d;
  logic          carry_q,  carry_d;
  logic          ovf_q,    ovf_d;
  logic [W-1:0]  a_q,      a_d;
  logic [W-1:0]  b_q,      b_d;
  logic [W-1:0]  result_q, result_d;

  // Two's-complement overflow from the operand sign bits and the result sign bit.
  function automatic logic signed_ovf(input logic sign_a, input logic sign_b,
                                      input logic sign_r);
    signed_ovf = (sign_a == sign_b) && (sign_r != sign_a);
  endfunction

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d      = op_a;
          b_d      = op_b;
          carry_d  = op_cin;
          idx_d    = IDX_ZERO;
          ovf_d    = 1'b0;
          result_d = {W{1'b0}};
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        result_d[{idx_q, 2'b00} +: 4] = add_sum;
        carry_d = add_cout;
        // Sign of the whole result is bit 3 of the last nibble's sum.
        if (idx_q == LAST_IDX) begin
          idx_d   = IDX_ZERO;
          ovf_d   = signed_ovf(a_q[W-1], b_q[W-1], add_sum[3]);
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = IDX_ZERO;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= IDX_ZERO;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      a_q      <= {W{1'b0}};
      b_q      <= {W{1'b0}};
      result_q <= {W{1'b0}};
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  // Output decode: adder is only driven in RUN, flags only shown in DONE.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    result    = result_q;
    if (state_q == S_RUN) begin
      add_a   = a_q[{idx_q, 2'b00} +: 4];
      add_b   = b_q[{idx_q, 2'b00} +: 4];
      add_cin = carry_q;
    end else begin
      add_a   = 4'h0;
      add_b   = 4'h0;
      add_cin = 1'b0;
    end
    if (state_q == S_DONE) begin
      cout = carry_q;
      ovf  = ovf_q;
    end else begin
      cout = 1'b0;
      ovf  = 1'b0;
    end
  end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Scoreboard bench for nibble_add_seq: 16-bit instance plus an exhaustive
// 4-bit (NIBBLES=1) instance, each paired with a behavioural 4-bit adder.
module tb_nibble_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, op_cin, out_valid, out_ready, cout, ovf;
  logic [15:0] op_a, op_b, result;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  logic        in_valid1, in_ready1, op_cin1, out_valid1, out_ready1, cout1, ovf1;
  logic [3:0]  op_a1, op_b1, result1;
  logic [3:0]  add_a1, add_b1, add_sum1;
  logic        add_cin1, add_cout1;

  assign {add_cout, add_sum}   = 5'(add_a)  + 5'(add_b)  + 5'(add_cin);
  assign {add_cout1, add_sum1} = 5'(add_a1) + 5'(add_b1) + 5'(add_cin1);

  nibble_add_seq #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovf(ovf)
  );

  nibble_add_seq #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .op_a(op_a1), .op_b(op_b1), .op_cin(op_cin1),
    .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1),
    .add_sum(add_sum1), .add_cout(add_cout1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .result(result1), .cout(cout1), .ovf(ovf1)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [17:0] exp_q[$];
  logic [5:0]  exp1_q[$];
  logic [17:0] mon_e;
  logic [5:0]  mon_e1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
  endtask

  // Reference: {cout, ovf, result} from plain integer addition.
  function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic c);
    logic [16:0] s;
    logic v;
    s = 17'(a) + 17'(b) + 17'(c);
    v = (a[15] == b[15]) && (s[15] != a[15]);
    return {s[16], v, s[15:0]};
  endfunction

  function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b,
                                        input logic c);
    logic [4:0] s;
    logic v;
    s = 5'(a) + 5'(b) + 5'(c);
    v = (a[3] == b[3]) && (s[3] != a[3]);
    return {s[4], v, s[3:0]};
  endfunction

  // Monitors: pop an expectation on every result handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      chk("sb16_expect_present", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("sb16_result", {14'd0, cout, ovf, result}, {14'd0, mon_e});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid1 && out_ready1) begin
      chk("sb4_expect_present", 32'(exp1_q.size() != 0), 32'd1);
      if (exp1_q.size() != 0) begin
        mon_e1 = exp1_q.pop_front();
        chk("sb4_result", {26'd0, cout1, ovf1, result1}, {26'd0, mon_e1});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input bit rnd);
    int t = 0;
    op_a = a; op_b = b; op_cin = c; in_valid = 1'b1;
    while (!in_ready && t < 40) begin
      @(posedge clk); #1; t++;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    chk("accept_wait", {31'd0, in_ready}, 32'd1);
    if (in_ready) exp_q.push_back(model16(a, b, c));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  initial begin
    int cyc;
    int t;
    rst_n = 1'b0; in_valid = 1'b0; op_a = 16'h0; op_b = 16'h0; op_cin = 1'b0;
    out_ready = 1'b0;
    in_valid1 = 1'b0; op_a1 = 4'h0; op_b1 = 4'h0; op_cin1 = 1'b0; out_ready1 = 1'b1;
    #12;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result",    {16'd0, result},    32'd0);
    chk("rst_flags",     {30'd0, cout, ovf}, 32'd0);
    chk("rst_adder",     {23'd0, add_a, add_b, add_cin}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency, then a held result with a competing operand bundle.
    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_valid(cyc);
    chk("latency_t1", cyc, 32'd4);
    op_a = 16'h0001; op_b = 16'h0001; op_cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid",    {31'd0, out_valid}, 32'd1);
      chk("stall_result",   {16'd0, result},    32'h5555);
      chk("stall_in_ready", {31'd0, in_ready},  32'd0);
      chk("stall_adder",    {23'd0, add_a, add_b, add_cin}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_in_ready", {31'd0, in_ready},  32'd1);
    chk("post_hs_valid",    {31'd0, out_valid}, 32'd0);
    chk("idle_flags",       {30'd0, cout, ovf}, 32'd0);
    exp_q.push_back(model16(16'h0001, 16'h0001, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pending_accepted", {31'd0, in_ready}, 32'd0);
    wait_valid(cyc);
    chk("latency_t4", cyc, 32'd4);
    @(posedge clk); #1;

    send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h8000, 16'h8000, 1'b0, 1'b0);

    // Abort mid-operation with reset at idx 2.
    send(16'h0A00, 16'h0500, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("run_idx2_add_a", {28'd0, add_a}, 32'hA);
    chk("run_idx2_add_b", {28'd0, add_b}, 32'h5);
    rst_n = 1'b0;
    #1;
    chk("abort_valid",    {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready},  32'd1);
    chk("abort_adder",    {23'd0, add_a, add_b, add_cin}, 32'd0);
    chk("abort_result",   {16'd0, result},    32'd0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h0001, 16'h0001, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end
    out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("drain16", 32'(exp_q.size()), 32'd0);

    // NIBBLES=1: every a/b/cin, one-cycle RUN.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          op_a1 = 4'(a); op_b1 = 4'(b); op_cin1 = 1'(c); in_valid1 = 1'b1;
          t = 0;
          while (!in_ready1 && t < 10) begin
            @(posedge clk); #1; t++;
          end
          chk("accept_wait1", {31'd0, in_ready1}, 32'd1);
          if (in_ready1) exp1_q.push_back(model4(4'(a), 4'(b), 1'(c)));
          @(posedge clk); #1;
          in_valid1 = 1'b0;
          @(posedge clk); #1;
          chk("run1_one_cycle", {31'd0, out_valid1}, 32'd1);
        end
      end
    end
    t = 0;
    while (exp1_q.size() != 0 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    chk("drain4", 32'(exp1_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
